dmem_bus_ctrl: RTL and testbench
================================

# dmem_bus_ctrl

Data-memory bus controller placed directly downstream of the MEM-stage CPU/memory interface. It consumes the stage's byte-enable, address and store-data outputs plus a request strobe. It runs one data-memory transaction per request over a valid/ready request channel and a valid response channel, and stalls the pipeline until the transaction completes. It also performs byte-lane alignment and misalignment and timeout detection, and returns the load word LSB-aligned to the load-extension logic.

## Interface
- TIMEOUT, 255: bus cycles (REQ+RESP) before an access is aborted with error; 1..65535.
- clk  in  1  pipeline clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- cpu_req  in  1  MEM stage holds a load or store this cycle.
- cpu_dwe  in  4  LSB-aligned byte enables: 0000 load, 0001 SB, 0011 SH, 1111 SW; other values treated as 1111.
- cpu_daddr  in  32  byte address (ALU result).
- cpu_dwdata  in  32  LSB-aligned store data (rs2).
- cpu_stall  out  1  freeze PC and all pipeline registers.
- cpu_rdata  out  32  load word, right-shifted by 8*daddr[1:0].
- cpu_rvalid  out  1  one-cycle completion pulse (loads and stores).
- cpu_err  out  1  with cpu_rvalid: misaligned store or timeout.
- bus_req_valid  out  1  request valid.
- bus_req_ready  in  1  bus accepts request.
- bus_addr  out  32  {daddr[31:2],2'b00}.
- bus_we  out  4  shifted byte enables; 0000 = read.
- bus_wdata  out  32  cpu_dwdata << 8*daddr[1:0].
- bus_rsp_valid  in  1  response/ack; earliest one cycle after acceptance.
- bus_rdata  in  32  read word.

## Operation
- States: IDLE, REQ, RESP, DONE.
- IDLE: on cpu_req, register bus_addr, bus_we and bus_wdata, and clear the counter.
  - Shifted mask (cpu_dwe << daddr[1:0]) crossing bit 3 is misaligned (SH at offset 3; SW at offset 1–3). Misaligned goes to DONE with err=1 and no bus activity.
  - Otherwise go to REQ.
  - Loads are never flagged misaligned. Bytes shifted in from above bit 31 read as 0.
- REQ: bus_req_valid=1, with address, data and enables held stable.
  - bus_req_ready=1 goes to RESP.
  - Counter reaching TIMEOUT goes to DONE with err=1.
- RESP: bus_req_valid=0.
  - bus_rsp_valid=1 captures bus_rdata >> 8*daddr[1:0] into cpu_rdata (unchanged for stores) and goes to DONE with err=0.
  - Counter reaching TIMEOUT goes to DONE with err=1 and rdata=0.
- DONE: cpu_rvalid=1, cpu_stall=0, then unconditionally IDLE. The stalled instruction still drives cpu_req here and must not start a second access.
- The counter increments every cycle in REQ and RESP and saturates at TIMEOUT.
- bus_rsp_valid outside RESP is ignored. Timed-out or reset-aborted responses are dropped.
- Error responses beyond timeout are not modelled.

## Timing
- cpu_stall = (IDLE & cpu_req) | REQ | RESP. This is combinational from cpu_req, so the stall is asserted in the request cycle.
- Zero-wait bus (ready held 1, response one cycle after acceptance):
  - request in cycle 0, REQ in cycle 1, RESP in cycle 2, DONE in cycle 3.
  - Stall covers 3 cycles; the instruction advances at the end of cycle 3.
- Misaligned store: stall for 1 cycle (IDLE), DONE next cycle.
- Timeout: DONE follows the cycle in which the counter reaches TIMEOUT.
- Back-to-back: a new cpu_req in the cycle after DONE is accepted normally. There is no dead cycle beyond DONE.
- Reset values:
  - state IDLE, counter 0.
  - bus_req_valid 0, bus_addr/bus_we/bus_wdata 0.
  - cpu_rdata 0, cpu_rvalid 0, cpu_err 0.
  - cpu_stall follows cpu_req while in IDLE.
- Reset mid-transaction: IDLE next cycle and bus_req_valid drops immediately. The outstanding response is ignored.

## Test plan
- SW 0xDEADBEEF to 0x100, zero-wait bus:
  - bus_addr=0x100, bus_we=1111, bus_wdata=0xDEADBEEF.
  - stall high for cycles 0–2; rvalid=1, err=0 in cycle 3.
- SB 0x000000AB to 0x203:
  - bus_addr=0x200, we=1000, wdata=0xAB000000.
- Load 0x102, bus returns 0x11223344 after 5 ready-low cycles and 3 response-wait cycles:
  - cpu_rdata=0x00001122.
  - stall stays high until DONE; bus_req_valid and bus_addr stay stable while ready is low.
- SH at 0x107:
  - no bus_req_valid.
  - one stall cycle, then rvalid=1, err=1.
- TIMEOUT=8, ready held 0: DONE after 8 REQ cycles with err=1 and rdata=0. A later stray bus_rsp_valid in IDLE has no effect.
- Reset asserted in RESP: next cycle IDLE with all outputs at reset values. A response arriving afterwards produces no rvalid, and the next SW completes normally.

Source files
------------

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: one valid/ready bus transaction per MEM-stage access,
// with byte-lane alignment, misalignment and timeout detection, and a pipeline stall.
module dmem_bus_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic [3:0]  cpu_dwe,
   input  logic [31:0] cpu_daddr,
   input  logic [31:0] cpu_dwdata,
   output logic        cpu_stall,
   output logic [31:0] cpu_rdata,
   output logic        cpu_rvalid,
   output logic        cpu_err,
   output logic        bus_req_valid,
   input  logic        bus_req_ready,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_we,
   output logic [31:0] bus_wdata,
   input  logic        bus_rsp_valid,
   input  logic [31:0] bus_rdata
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] RESP = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);

   logic [1:0]  state;
   logic [15:0] cnt;
   logic [15:0] cnt_next;
   logic [1:0]  off;
   logic        err_q;

   logic [3:0]  dwe_eff;
   logic [7:0]  mask_wide;
   logic        is_store;
   logic        misaligned;
   logic        tmo_hit;
   logic [31:0] rdata_aligned;

   // Unrecognised enable patterns are treated as a full-word store.
   always_comb begin
      dwe_eff = 4'b1111;
      case (cpu_dwe)
         4'b0000: dwe_eff = 4'b0000;
         4'b0001: dwe_eff = 4'b0001;
         4'b0011: dwe_eff = 4'b0011;
         default: dwe_eff = 4'b1111;
      endcase
   end

   assign mask_wide     = {4'b0000, dwe_eff} << cpu_daddr[1:0];
   assign is_store      = |dwe_eff;
   assign misaligned    = is_store & (|mask_wide[7:4]);
   assign cnt_next      = (cnt == TMO_LIMIT) ? cnt : cnt + 16'd1;
   // The counter value after this cycle's increment is what reaches the limit.
   assign tmo_hit       = (cnt >= TMO_LIMIT - 16'd1);
   assign rdata_aligned = bus_rdata >> {off, 3'b000};

   assign cpu_stall     = ((state == IDLE) & cpu_req) | (state == REQ) | (state == RESP);
   assign cpu_rvalid    = (state == DONE);
   assign cpu_err       = err_q;
   assign bus_req_valid = (state == REQ) & ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 16'd0;
         off       <= 2'd0;
         err_q     <= 1'b0;
         bus_addr  <= 32'd0;
         bus_we    <= 4'd0;
         bus_wdata <= 32'd0;
         cpu_rdata <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_req) begin
                  bus_addr  <= {cpu_daddr[31:2], 2'b00};
                  bus_we    <= mask_wide[3:0];
                  bus_wdata <= cpu_dwdata << {cpu_daddr[1:0], 3'b000};
                  off       <= cpu_daddr[1:0];
                  cnt       <= 16'd0;
                  if (misaligned) begin
                     state <= DONE;
                     err_q <= 1'b1;
                  end else begin
                     state <= REQ;
                  end
               end
            end
            REQ: begin
               cnt <= cnt_next;
               if (bus_req_ready) begin
                  state <= RESP;
               end else if (tmo_hit) begin
                  state     <= DONE;
                  err_q     <= 1'b1;
                  cpu_rdata <= 32'd0;
               end
            end
            RESP: begin
               cnt <= cnt_next;
               if (bus_rsp_valid) begin
                  if (bus_we == 4'd0) begin
                     cpu_rdata <= rdata_aligned;
                  end
                  state <= DONE;
                  err_q <= 1'b0;
               end else if (tmo_hit) begin
                  state     <= DONE;
                  err_q     <= 1'b1;
                  cpu_rdata <= 32'd0;
               end
            end
            default: begin
               // DONE always returns to IDLE, so a still-asserted cpu_req cannot relaunch.
               state <= IDLE;
               err_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed table-driven bench for dmem_bus_ctrl plus timeout and reset sequences.
module tb_dmem_bus_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req;
   logic [3:0]  cpu_dwe;
   logic [31:0] cpu_daddr;
   logic [31:0] cpu_dwdata;
   logic        bus_req_ready;
   logic        bus_rsp_valid;
   logic [31:0] bus_rdata;

   logic        cpu_stall, cpu_rvalid, cpu_err, bus_req_valid;
   logic [31:0] cpu_rdata, bus_addr, bus_wdata;
   logic [3:0]  bus_we;

   logic        t_stall, t_rvalid, t_err, t_req_valid;
   logic [31:0] t_rdata, t_addr, t_wdata;
   logic [3:0]  t_we;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_bus_ctrl dut (
      .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_dwe(cpu_dwe),
      .cpu_daddr(cpu_daddr), .cpu_dwdata(cpu_dwdata), .cpu_stall(cpu_stall),
      .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_err(cpu_err),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
      .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata),
      .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
   );

   dmem_bus_ctrl #(.TIMEOUT(8)) dut_t (
      .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_dwe(cpu_dwe),
      .cpu_daddr(cpu_daddr), .cpu_dwdata(cpu_dwdata), .cpu_stall(t_stall),
      .cpu_rdata(t_rdata), .cpu_rvalid(t_rvalid), .cpu_err(t_err),
      .bus_req_valid(t_req_valid), .bus_req_ready(bus_req_ready),
      .bus_addr(t_addr), .bus_we(t_we), .bus_wdata(t_wdata),
      .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
   );

   typedef struct {
      logic [3:0]  dwe;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          ready_lo;
      int          rsp_wait;
      logic [31:0] word;
      logic        mis;
      logic [31:0] e_addr;
      logic [3:0]  e_we;
      logic [31:0] e_wdata;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One access, cycle by cycle; cpu_req stays high through DONE like a stalled instruction.
   task automatic run_vec(input vec_t v, input int idx);
      cpu_req       = 1'b1;
      cpu_dwe       = v.dwe;
      cpu_daddr     = v.addr;
      cpu_dwdata    = v.wdata;
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_idle_stall", idx), cpu_stall, 1);
      chk($sformatf("v%0d_idle_reqv", idx), bus_req_valid, 0);
      step();
      if (!v.mis) begin
         for (int i = 0; i <= v.ready_lo; i++) begin
            bus_req_ready = (i == v.ready_lo);
            bus_rsp_valid = (i < v.ready_lo);
            bus_rdata     = 32'hFFFF_FFFF;
            @(negedge clk);
            chk($sformatf("v%0d_req_reqv", idx), bus_req_valid, 1);
            chk($sformatf("v%0d_req_stall", idx), cpu_stall, 1);
            chk($sformatf("v%0d_addr", idx), bus_addr, v.e_addr);
            chk($sformatf("v%0d_we", idx), bus_we, v.e_we);
            chk($sformatf("v%0d_wdata", idx), bus_wdata, v.e_wdata);
            step();
         end
         bus_req_ready = 1'b0;
         for (int j = 0; j <= v.rsp_wait; j++) begin
            bus_rsp_valid = (j == v.rsp_wait);
            bus_rdata     = (j == v.rsp_wait) ? v.word : 32'hFFFF_FFFF;
            @(negedge clk);
            chk($sformatf("v%0d_resp_reqv", idx), bus_req_valid, 0);
            chk($sformatf("v%0d_resp_stall", idx), cpu_stall, 1);
            chk($sformatf("v%0d_resp_rvalid", idx), cpu_rvalid, 0);
            step();
         end
         bus_rsp_valid = 1'b0;
         bus_rdata     = 32'd0;
      end
      @(negedge clk);
      chk($sformatf("v%0d_done_rvalid", idx), cpu_rvalid, 1);
      chk($sformatf("v%0d_done_err", idx), cpu_err, v.mis);
      chk($sformatf("v%0d_done_stall", idx), cpu_stall, 0);
      chk($sformatf("v%0d_done_reqv", idx), bus_req_valid, 0);
      if (!v.mis && v.e_we == 4'd0)
         chk($sformatf("v%0d_rdata", idx), cpu_rdata, v.e_rdata);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n_req;
      logic seen;

      //           dwe    addr         wdata         rl rw word          mis  e_addr       e_we   e_wdata       e_rdata
      vecs[0]  = '{4'hF, 32'h100,     32'hDEADBEEF, 0, 0, 32'h0,        1'b0, 32'h100,     4'hF, 32'hDEADBEEF, 32'h0};
      vecs[1]  = '{4'h1, 32'h203,     32'h000000AB, 0, 0, 32'h0,        1'b0, 32'h200,     4'h8, 32'hAB000000, 32'h0};
      vecs[2]  = '{4'h0, 32'h102,     32'h0,        5, 3, 32'h11223344, 1'b0, 32'h100,     4'h0, 32'h0,        32'h00001122};
      vecs[3]  = '{4'h3, 32'h107,     32'h0000BEEF, 0, 0, 32'h0,        1'b1, 32'h0,       4'h0, 32'h0,        32'h0};
      vecs[4]  = '{4'h3, 32'h102,     32'h0000BEEF, 0, 0, 32'h0,        1'b0, 32'h100,     4'hC, 32'hBEEF0000, 32'h0};
      vecs[5]  = '{4'h0, 32'h203,     32'h0,        0, 1, 32'hA1B2C3D4, 1'b0, 32'h200,     4'h0, 32'h0,        32'h000000A1};
      vecs[6]  = '{4'h0, 32'h40,      32'h0,        2, 0, 32'hCAFEF00D, 1'b0, 32'h40,      4'h0, 32'h0,        32'hCAFEF00D};
      vecs[7]  = '{4'hF, 32'h101,     32'h12345678, 0, 0, 32'h0,        1'b1, 32'h0,       4'h0, 32'h0,        32'h0};
      vecs[8]  = '{4'h5, 32'h204,     32'h12345678, 1, 0, 32'h0,        1'b0, 32'h204,     4'hF, 32'h12345678, 32'h0};
      vecs[9]  = '{4'h1, 32'h001,     32'h00000034, 0, 2, 32'h0,        1'b0, 32'h0,       4'h2, 32'h00003400, 32'h0};
      vecs[10] = '{4'h0, 32'h305,     32'hFFFFFFFF, 0, 0, 32'h55667788, 1'b0, 32'h304,     4'h0, 32'hFFFFFF00, 32'h00556677};
      vecs[11] = '{4'h6, 32'h001,     32'h0,        0, 0, 32'h0,        1'b1, 32'h0,       4'h0, 32'h0,        32'h0};

      reset = 1'b1; cpu_req = 1'b0; cpu_dwe = 4'd0; cpu_daddr = 32'd0; cpu_dwdata = 32'd0;
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'd0;
      step();
      step();
      @(negedge clk);
      chk("rst_reqv", bus_req_valid, 0);
      chk("rst_addr", bus_addr, 0);
      chk("rst_we", bus_we, 0);
      chk("rst_wdata", bus_wdata, 0);
      chk("rst_rdata", cpu_rdata, 0);
      chk("rst_rvalid", cpu_rvalid, 0);
      chk("rst_err", cpu_err, 0);
      chk("rst_stall_lo", cpu_stall, 0);
      cpu_req = 1'b1;
      #1;
      chk("rst_stall_follows_req", cpu_stall, 1);
      step();
      reset = 1'b0;
      cpu_req = 1'b0;

      // Back-to-back accesses: each one starts in the cycle right after the previous DONE.
      for (int k = 0; k < 12; k++) run_vec(vecs[k], k);

      // Reset while waiting for a response.
      cpu_req = 1'b1; cpu_dwe = 4'hF; cpu_daddr = 32'h500; cpu_dwdata = 32'h0BADF00D;
      bus_req_ready = 1'b1;
      step();
      step();
      bus_req_ready = 1'b0;
      @(negedge clk);
      chk("rr_in_resp_stall", cpu_stall, 1);
      chk("rr_in_resp_addr", bus_addr, 32'h500);
      step();
      reset = 1'b1;
      cpu_req = 1'b0;
      @(negedge clk);
      chk("rr_reqv_during_reset", bus_req_valid, 0);
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("rr_stall", cpu_stall, 0);
      chk("rr_rvalid", cpu_rvalid, 0);
      chk("rr_err", cpu_err, 0);
      chk("rr_rdata", cpu_rdata, 0);
      chk("rr_addr", bus_addr, 0);
      chk("rr_we", bus_we, 0);
      chk("rr_wdata", bus_wdata, 0);
      chk("rr_reqv", bus_req_valid, 0);
      bus_rsp_valid = 1'b1;
      bus_rdata = 32'h77777777;
      step();
      bus_rsp_valid = 1'b0;
      @(negedge clk);
      chk("rr_late_rsp_rvalid", cpu_rvalid, 0);
      chk("rr_late_rsp_rdata", cpu_rdata, 0);
      step();
      run_vec(vecs[0], 100);

      // Timeout instance: first a load that leaves nonzero rdata, then a load that times out.
      reset = 1'b1;
      cpu_req = 1'b0;
      step();
      reset = 1'b0;
      cpu_req = 1'b1; cpu_dwe = 4'h0; cpu_daddr = 32'h0; cpu_dwdata = 32'h0;
      bus_req_ready = 1'b1;
      step();
      step();
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b1;
      bus_rdata = 32'h00000099;
      step();
      bus_rsp_valid = 1'b0;
      @(negedge clk);
      chk("to_pre_rvalid", t_rvalid, 1);
      chk("to_pre_rdata", t_rdata, 32'h99);
      cpu_req = 1'b0;
      step();
      cpu_req = 1'b1; cpu_daddr = 32'h300;
      step();
      n_req = 0;
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         if (t_rvalid) seen = 1'b1;
         else begin
            if (t_req_valid) n_req++;
            step();
         end
      end
      chk("to_done_reached", seen, 1);
      chk("to_req_cycles", n_req, 8);
      chk("to_err", t_err, 1);
      chk("to_rdata", t_rdata, 0);
      chk("to_done_reqv", t_req_valid, 0);
      cpu_req = 1'b0;
      step();
      bus_rsp_valid = 1'b1;
      bus_rdata = 32'hDEAD0000;
      step();
      bus_rsp_valid = 1'b0;
      @(negedge clk);
      chk("to_stray_rvalid", t_rvalid, 0);
      chk("to_stray_stall", t_stall, 0);
      chk("to_stray_rdata", t_rdata, 0);
      chk("to_stray_reqv", t_req_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
